// File: rtl/sap1_pkg.sv
// Shared definitions for the SAP-1 controller-sequencer: opcodes, T-state
// indices and the packed control word driven to the datapath.
package sap1_pkg;

  localparam int unsigned OP_W = 4;
  localparam int unsigned T_W  = 6;

  localparam logic [OP_W-1:0] OP_LDA = 4'b0000;
  localparam logic [OP_W-1:0] OP_ADD = 4'b0001;
  localparam logic [OP_W-1:0] OP_SUB = 4'b0010;
  localparam logic [OP_W-1:0] OP_OUT = 4'b1110;
  localparam logic [OP_W-1:0] OP_HLT = 4'b1111;

  // Bit positions of each T state in the one-hot ring
  localparam int unsigned T1 = 0;
  localparam int unsigned T2 = 1;
  localparam int unsigned T3 = 2;
  localparam int unsigned T4 = 3;
  localparam int unsigned T5 = 4;
  localparam int unsigned T6 = 5;

  typedef struct packed {
    logic cp;
    logic ep;
    logic lm;
    logic ce;
    logic li;
    logic ei;
    logic la;
    logic ea;
    logic su;
    logic eu;
    logic lb;
    logic lo;
  } ctrl_word_t;

  localparam ctrl_word_t CTRL_NOP = '0;

  // True for the five opcodes the machine implements
  function automatic logic op_defined(input logic [OP_W-1:0] op);
    return (op == OP_LDA) || (op == OP_ADD) || (op == OP_SUB) ||
           (op == OP_OUT) || (op == OP_HLT);
  endfunction

endpackage

// File: rtl/ring_counter.sv
// Six-bit one-hot rotator stepping T1..T6.
//   CLK  : rising-edge clock
//   CLR  : synchronous active-high load of T1
//   HOLD : freeze the current state
//   T    : one-hot state, bit0 = T1
module ring_counter
  import sap1_pkg::*;
(
  input  logic           CLK,
  input  logic           CLR,
  input  logic           HOLD,
  output logic [T_W-1:0] T
);

  logic [T_W-1:0] t_q, t_d;

  // Rotate left one position unless held
  always_comb begin
    t_d = t_q;
    if (!HOLD) t_d = {t_q[T_W-2:0], t_q[T_W-1]};
  end

  always_ff @(posedge CLK) begin
    if (CLR) t_q <= T_W'(1);
    else     t_q <= t_d;
  end

  assign T = t_q;

endmodule

// File: rtl/controller_sequencer.sv
// SAP-1 controller-sequencer: ring-counter timing, opcode decode into the
// datapath control word, and the HLT latch.
//   CLK, CLR : clock and synchronous active-high reset
//   OPCODE   : IR upper nibble (meaningful in T4..T6)
//   T        : one-hot T state
//   CP..LO   : combinational control lines to the datapath
//   HLT      : machine halted (held until CLR)
module controller_sequencer
  import sap1_pkg::*;
#(
  parameter bit HALT_ON_UNDEF = 1'b0
) (
  input  logic            CLK,
  input  logic            CLR,
  input  logic [OP_W-1:0] OPCODE,
  output logic [T_W-1:0]  T,
  output logic            CP,
  output logic            EP,
  output logic            LM,
  output logic            CE,
  output logic            LI,
  output logic            EI,
  output logic            LA,
  output logic            EA,
  output logic            SU,
  output logic            EU,
  output logic            LB,
  output logic            LO,
  output logic            HLT
);

  logic [T_W-1:0] ring_t;
  logic           halt_q, halt_d;
  logic           stop_c;
  ctrl_word_t     ctrl;

  // Ring holds both while latched and on the edge that sets the latch,
  // so the machine parks in T4.
  ring_counter u_ring (
    .CLK  (CLK),
    .CLR  (CLR),
    .HOLD (halt_q | stop_c),
    .T    (ring_t)
  );

  // Halt request decoded in T4
  always_comb begin
    stop_c = 1'b0;
    if (!CLR && !halt_q && ring_t[T4])
      stop_c = (OPCODE == OP_HLT) || (HALT_ON_UNDEF && !op_defined(OPCODE));
    halt_d = halt_q | stop_c;
  end

  always_ff @(posedge CLK) begin
    if (CLR) halt_q <= 1'b0;
    else     halt_q <= halt_d;
  end

  // Control-word decode; everything quiet during reset or halt
  always_comb begin
    ctrl = CTRL_NOP;
    if (!CLR && !halt_q && !stop_c) begin
      if (ring_t[T1]) begin
        ctrl.ep = 1'b1;
        ctrl.lm = 1'b1;
      end else if (ring_t[T2]) begin
        ctrl.cp = 1'b1;
      end else if (ring_t[T3]) begin
        ctrl.ce = 1'b1;
        ctrl.li = 1'b1;
      end else if (ring_t[T4]) begin
        case (OPCODE)
          OP_LDA, OP_ADD, OP_SUB: begin
            ctrl.ei = 1'b1;
            ctrl.lm = 1'b1;
          end
          OP_OUT: begin
            ctrl.ea = 1'b1;
            ctrl.lo = 1'b1;
          end
          default: ;
        endcase
      end else if (ring_t[T5]) begin
        case (OPCODE)
          OP_LDA: begin
            ctrl.ce = 1'b1;
            ctrl.la = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            ctrl.ce = 1'b1;
            ctrl.lb = 1'b1;
          end
          default: ;
        endcase
      end else if (ring_t[T6]) begin
        case (OPCODE)
          OP_ADD: begin
            ctrl.eu = 1'b1;
            ctrl.la = 1'b1;
          end
          OP_SUB: begin
            ctrl.su = 1'b1;
            ctrl.eu = 1'b1;
            ctrl.la = 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  // T reads as T1 for the whole time CLR is asserted
  assign T   = CLR ? T_W'(1) : ring_t;
  assign HLT = !CLR && (halt_q || stop_c);

  assign CP = ctrl.cp;
  assign EP = ctrl.ep;
  assign LM = ctrl.lm;
  assign CE = ctrl.ce;
  assign LI = ctrl.li;
  assign EI = ctrl.ei;
  assign LA = ctrl.la;
  assign EA = ctrl.ea;
  assign SU = ctrl.su;
  assign EU = ctrl.eu;
  assign LB = ctrl.lb;
  assign LO = ctrl.lo;

endmodule

// File: tb/tb_controller_sequencer.sv
// Bench for controller_sequencer: two instances (HALT_ON_UNDEF = 0 and 1)
// share stimulus and are compared each cycle against a step/halted model.
module tb_controller_sequencer;

  localparam logic [11:0] M_CP = 12'h800;
  localparam logic [11:0] M_EP = 12'h400;
  localparam logic [11:0] M_LM = 12'h200;
  localparam logic [11:0] M_CE = 12'h100;
  localparam logic [11:0] M_LI = 12'h080;
  localparam logic [11:0] M_EI = 12'h040;
  localparam logic [11:0] M_LA = 12'h020;
  localparam logic [11:0] M_EA = 12'h010;
  localparam logic [11:0] M_SU = 12'h008;
  localparam logic [11:0] M_EU = 12'h004;
  localparam logic [11:0] M_LB = 12'h002;
  localparam logic [11:0] M_LO = 12'h001;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic [3:0] op  = 4'd0;

  logic [5:0] t_o [2];
  logic [1:0] cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo, hlt;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state per instance: T index 0..5 and halted flag
  int step    [2];
  bit halted  [2];
  bit hou     [2];

  always #5 clk = ~clk;

  controller_sequencer #(.HALT_ON_UNDEF(1'b0)) u_dut0 (
    .CLK(clk), .CLR(clr), .OPCODE(op), .T(t_o[0]),
    .CP(cp[0]), .EP(ep[0]), .LM(lm[0]), .CE(ce[0]), .LI(li[0]), .EI(ei[0]),
    .LA(la[0]), .EA(ea[0]), .SU(su[0]), .EU(eu[0]), .LB(lb[0]), .LO(lo[0]),
    .HLT(hlt[0])
  );

  controller_sequencer #(.HALT_ON_UNDEF(1'b1)) u_dut1 (
    .CLK(clk), .CLR(clr), .OPCODE(op), .T(t_o[1]),
    .CP(cp[1]), .EP(ep[1]), .LM(lm[1]), .CE(ce[1]), .LI(li[1]), .EI(ei[1]),
    .LA(la[1]), .EA(ea[1]), .SU(su[1]), .EU(eu[1]), .LB(lb[1]), .LO(lo[1]),
    .HLT(hlt[1])
  );

  task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Instruction table: control lines for a T index and opcode
  function automatic logic [11:0] exp_ctrl(input int s, input logic [3:0] o);
    logic [11:0] r;
    r = 12'h000;
    case (s)
      0: r = M_EP | M_LM;
      1: r = M_CP;
      2: r = M_CE | M_LI;
      3: if (o == 4'h0 || o == 4'h1 || o == 4'h2) r = M_EI | M_LM;
         else if (o == 4'he)                     r = M_EA | M_LO;
      4: if (o == 4'h0)                     r = M_CE | M_LA;
         else if (o == 4'h1 || o == 4'h2)   r = M_CE | M_LB;
      5: if (o == 4'h1)      r = M_EU | M_LA;
         else if (o == 4'h2) r = M_SU | M_EU | M_LA;
      default: r = 12'h000;
    endcase
    return r;
  endfunction

  function automatic bit is_undef(input logic [3:0] o);
    return !(o == 4'h0 || o == 4'h1 || o == 4'h2 || o == 4'he || o == 4'hf);
  endfunction

  // Apply inputs for one cycle, check both instances, advance the model
  task automatic cycle(input logic c, input logic [3:0] o);
    bit          stop;
    logic [5:0]  et;
    logic [11:0] ec, cw;
    logic        eh;
    int          nbus;
    @(negedge clk);
    clr = c;
    op  = o;
    #1;
    for (int i = 0; i < 2; i++) begin
      stop = !c && !halted[i] && step[i] == 3 && (o == 4'hf || (hou[i] && is_undef(o)));
      et   = c ? 6'd1 : 6'(1 << step[i]);
      eh   = !c && (halted[i] || stop);
      ec   = (c || halted[i] || stop) ? 12'h000 : exp_ctrl(step[i], o);
      cw   = {cp[i], ep[i], lm[i], ce[i], li[i], ei[i], la[i], ea[i], su[i], eu[i], lb[i], lo[i]};
      nbus = int'(ep[i]) + int'(ce[i]) + int'(ei[i]) + int'(ea[i]) + int'(eu[i]);
      check($sformatf("u%0d.T", i),    12'(t_o[i]), 12'(et));
      check($sformatf("u%0d.HLT", i),  12'(hlt[i]), 12'(eh));
      check($sformatf("u%0d.CTRL", i), cw, ec);
      check($sformatf("u%0d.BUSX", i), 12'(nbus <= 1), 12'd1);
      if (c) begin
        step[i]   = 0;
        halted[i] = 1'b0;
      end else if (!halted[i]) begin
        if (stop) halted[i] = 1'b1;
        else      step[i]   = (step[i] + 1) % 6;
      end
    end
  endtask

  // Fetch with scrambled opcode, then execute with the given opcode
  task automatic instr(input logic [3:0] o);
    for (int k = 0; k < 3; k++) cycle(1'b0, 4'($urandom));
    for (int k = 0; k < 3; k++) cycle(1'b0, o);
  endtask

  initial begin
    step   = '{0, 0};
    halted = '{1'b0, 1'b0};
    hou    = '{1'b0, 1'b1};

    // Reset held two cycles, then normal instructions
    cycle(1'b1, 4'h0);
    cycle(1'b1, 4'h0);
    instr(4'h0);
    instr(4'h0);
    instr(4'h1);
    instr(4'h2);
    instr(4'he);
    instr(4'hf);
    for (int k = 0; k < 10; k++) cycle(1'b0, 4'($urandom));
    cycle(1'b1, 4'h0);

    // Reset during T5 of ADD
    for (int k = 0; k < 3; k++) cycle(1'b0, 4'($urandom));
    cycle(1'b0, 4'h1);
    cycle(1'b1, 4'h1);
    instr(4'h1);

    // Undefined opcode: NOP in one instance, halt in the other
    instr(4'h5);
    for (int k = 0; k < 4; k++) cycle(1'b0, 4'h5);
    cycle(1'b1, 4'h0);

    // Random traffic
    for (int k = 0; k < 800; k++)
      cycle(($urandom_range(0, 24) == 0), 4'($urandom));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
